// File: rtl/sm83_pkg.sv
// Shared SM83 fetch definitions: FSM states, the CB prefix byte and the
// opcode -> instruction-length table.
package sm83_pkg;

  typedef enum logic [2:0] {
    S_OP,
    S_CB,
    S_LO,
    S_HI,
    S_OUT
  } state_t;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  // Unlisted opcodes, including the illegal D3/DB/DD/E3/E4/EB/EC/ED/F4/FC/FD, are one byte.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op)
      8'h01, 8'h08, 8'h11, 8'h21, 8'h31,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC,
      8'hEA, 8'hFA:
        len = 2'd3;
      8'h06, 8'h0E, 8'h10, 8'h16, 8'h18, 8'h1E,
      8'h20, 8'h26, 8'h28, 8'h2E,
      8'h30, 8'h36, 8'h38, 8'h3E,
      8'hC6, 8'hCB, 8'hCE, 8'hD6, 8'hDE,
      8'hE0, 8'hE6, 8'hE8, 8'hEE,
      8'hF0, 8'hF6, 8'hF8, 8'hFE:
        len = 2'd2;
      default:
        len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// SM83 instruction fetch: pulls 1..3 bytes (or CB + opcode) through a byte-wide
// read port, pulsing the PC counter once per byte, and hands one bundle to decode.
module instr_fetch
  import sm83_pkg::*;
(
  input  logic        IF_CLK,
  input  logic        IF_RST,
  input  logic [15:0] IF_PC,
  output logic        IF_PC_INC,
  input  logic        IF_FLUSH,
  output logic [15:0] IF_MEM_ADDR,
  output logic        IF_MEM_RD,
  input  logic [7:0]  IF_MEM_DATA,
  input  logic        IF_MEM_VALID,
  output logic [7:0]  IF_OPCODE,
  output logic        IF_CB,
  output logic [15:0] IF_IMM,
  output logic [1:0]  IF_LEN,
  output logic [15:0] IF_INSTR_PC,
  output logic        IF_VALID,
  input  logic        IF_READY
);

  state_t      state;
  logic        run;
  logic        capture;
  logic [1:0]  byte_len;
  logic        valid_q;
  logic        cb_q;
  logic [1:0]  len_q;
  logic [7:0]  opcode_q;
  logic [15:0] imm_q;
  logic [15:0] instr_pc_q;

  // run stays low for the first cycle after reset so the restart read is one cycle clean of IF_RST
  assign IF_MEM_RD   = run && !IF_RST && (state != S_OUT);
  assign IF_MEM_ADDR = IF_PC;
  assign capture     = IF_MEM_RD && IF_MEM_VALID && !IF_FLUSH;
  assign IF_PC_INC   = capture;
  assign byte_len    = op_len(IF_MEM_DATA);

  assign IF_VALID    = valid_q;
  assign IF_CB       = cb_q;
  assign IF_LEN      = len_q;
  assign IF_OPCODE   = opcode_q;
  assign IF_IMM      = imm_q;
  assign IF_INSTR_PC = instr_pc_q;

  always_ff @(posedge IF_CLK) begin
    if (IF_RST) begin
      state      <= S_OP;
      run        <= 1'b0;
      valid_q    <= 1'b0;
      cb_q       <= 1'b0;
      len_q      <= 2'd0;
      opcode_q   <= 8'h00;
      imm_q      <= 16'h0000;
      instr_pc_q <= 16'h0000;
    end else begin
      run <= 1'b1;
      if (IF_FLUSH) begin
        state   <= S_OP;
        valid_q <= 1'b0;
      end else begin
        case (state)
          S_OP: begin
            if (capture) begin
              instr_pc_q <= IF_PC;
              opcode_q   <= IF_MEM_DATA;
              cb_q       <= 1'b0;
              imm_q      <= 16'h0000;
              if (IF_MEM_DATA == CB_PREFIX) begin
                len_q <= 2'd2;
                state <= S_CB;
              end else begin
                len_q <= byte_len;
                if (byte_len == 2'd1) begin
                  state   <= S_OUT;
                  valid_q <= 1'b1;
                end else begin
                  state <= S_LO;
                end
              end
            end
          end
          S_CB: begin
            if (capture) begin
              opcode_q <= IF_MEM_DATA;
              cb_q     <= 1'b1;
              len_q    <= 2'd2;
              imm_q    <= 16'h0000;
              state    <= S_OUT;
              valid_q  <= 1'b1;
            end
          end
          S_LO: begin
            if (capture) begin
              imm_q <= {8'h00, IF_MEM_DATA};
              if (len_q == 2'd3) begin
                state <= S_HI;
              end else begin
                state   <= S_OUT;
                valid_q <= 1'b1;
              end
            end
          end
          S_HI: begin
            if (capture) begin
              imm_q[15:8] <= IF_MEM_DATA;
              state       <= S_OUT;
              valid_q     <= 1'b1;
            end
          end
          S_OUT: begin
            if (IF_READY) begin
              state   <= S_OP;
              valid_q <= 1'b0;
            end
          end
          default: begin
            state   <= S_OP;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: byte memory with programmable wait states, a PC counter
// model, and a scoreboard monitor that checks every delivered bundle.
module tb_instr_fetch;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
  } bundle_t;

  logic        IF_CLK = 1'b0;
  logic        IF_RST;
  logic [15:0] IF_PC;
  logic        IF_PC_INC;
  logic        IF_FLUSH;
  logic [15:0] IF_MEM_ADDR;
  logic        IF_MEM_RD;
  logic [7:0]  IF_MEM_DATA;
  logic        IF_MEM_VALID;
  logic [7:0]  IF_OPCODE;
  logic        IF_CB;
  logic [15:0] IF_IMM;
  logic [1:0]  IF_LEN;
  logic [15:0] IF_INSTR_PC;
  logic        IF_VALID;
  logic        IF_READY;

  logic [7:0]  mem [0:65535];
  logic [15:0] load_pc;
  int          inc_cnt;
  int          mem_wait = 0;
  bundle_t     exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  instr_fetch dut (
    .IF_CLK      (IF_CLK),
    .IF_RST      (IF_RST),
    .IF_PC       (IF_PC),
    .IF_PC_INC   (IF_PC_INC),
    .IF_FLUSH    (IF_FLUSH),
    .IF_MEM_ADDR (IF_MEM_ADDR),
    .IF_MEM_RD   (IF_MEM_RD),
    .IF_MEM_DATA (IF_MEM_DATA),
    .IF_MEM_VALID(IF_MEM_VALID),
    .IF_OPCODE   (IF_OPCODE),
    .IF_CB       (IF_CB),
    .IF_IMM      (IF_IMM),
    .IF_LEN      (IF_LEN),
    .IF_INSTR_PC (IF_INSTR_PC),
    .IF_VALID    (IF_VALID),
    .IF_READY    (IF_READY)
  );

  always #5 IF_CLK = ~IF_CLK;

  // PC counter: loads on reset/flush, increments on each pulse; inc_cnt counts pulses per bundle
  always @(posedge IF_CLK) begin
    if (IF_RST || IF_FLUSH) begin
      IF_PC   <= load_pc;
      inc_cnt <= 0;
    end else begin
      if (IF_PC_INC) IF_PC <= IF_PC + 16'd1;
      if (IF_VALID && IF_READY) inc_cnt <= 0;
      else if (IF_PC_INC) inc_cnt <= inc_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers a held read after mem_wait idle cycles at the same address
  initial begin
    logic [15:0] last_addr;
    logic        last_rd;
    int          cnt;
    IF_MEM_VALID = 1'b0;
    IF_MEM_DATA  = 8'h00;
    last_addr    = 16'h0000;
    last_rd      = 1'b0;
    cnt          = 0;
    forever begin
      @(negedge IF_CLK);
      if (IF_MEM_RD === 1'b1 && last_rd && IF_MEM_ADDR == last_addr) cnt++;
      else cnt = 0;
      last_rd   = (IF_MEM_RD === 1'b1);
      last_addr = IF_MEM_ADDR;
      if (IF_MEM_RD === 1'b1 && cnt >= mem_wait) begin
        IF_MEM_VALID = 1'b1;
        IF_MEM_DATA  = mem[IF_MEM_ADDR];
      end else begin
        IF_MEM_VALID = 1'b0;
        IF_MEM_DATA  = 8'h5A;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    bundle_t e;
    logic    prev_valid;
    logic    have_e;
    e          = '0;
    prev_valid = 1'b0;
    have_e     = 1'b0;
    forever begin
      @(negedge IF_CLK);
      #1;
      if (IF_VALID === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          have_e = 1'b0;
          $display("FAIL unexpected_bundle: got opcode 0x%0h at 0x%0h, expected no bundle", IF_OPCODE, IF_INSTR_PC);
        end else begin
          e      = exp_q.pop_front();
          have_e = 1'b1;
          chk("opcode",     IF_OPCODE,   e.opcode);
          chk("cb",         IF_CB,       e.cb);
          chk("imm",        IF_IMM,      e.imm);
          chk("len",        IF_LEN,      e.len);
          chk("instr_pc",   IF_INSTR_PC, e.pc);
          chk("inc_pulses", inc_cnt,     e.len);
          chk("pc_after",   IF_PC,       16'(e.pc + 16'(e.len)));
        end
      end else if (IF_VALID === 1'b1 && have_e) begin
        chk("bundle_hold", {IF_OPCODE, IF_CB, IF_IMM, IF_LEN, IF_INSTR_PC, IF_MEM_RD, IF_PC_INC},
            {e.opcode, e.cb, e.imm, e.len, e.pc, 2'b00});
      end
      prev_valid = (IF_VALID === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic push(input logic [7:0] op, input logic cb, input logic [15:0] imm,
                      input logic [1:0] len, input logic [15:0] pc);
    bundle_t b;
    b = '{opcode: op, cb: cb, imm: imm, len: len, pc: pc};
    exp_q.push_back(b);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge IF_CLK);
      #1;
      n++;
    end while (IF_VALID !== 1'b1 && n < 60);
    if (IF_VALID !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no IF_VALID, expected a bundle within 60 cycles", name);
    end
  endtask

  task automatic accept_and_jump(input logic [15:0] addr);
    IF_READY = 1'b1;
    @(negedge IF_CLK);
    #1;
    IF_READY = 1'b0;
    IF_FLUSH = 1'b1;
    load_pc  = addr;
    @(negedge IF_CLK);
    #1;
    IF_FLUSH = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h00;
    {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203], mem[16'h0204]} = 40'h01_34_12_18_FE;
    {mem[16'h0300], mem[16'h0301]} = 16'hCB_7C;
    {mem[16'h0400], mem[16'h0401], mem[16'h0402]} = 24'h21_CD_AB;
    {mem[16'h0500], mem[16'h0501], mem[16'h0502]} = 24'h21_11_22;
    {mem[16'h0600], mem[16'h0601]} = 16'h3E_55;
    {mem[16'h0700], mem[16'h0701], mem[16'h0702]} = 24'hFA_34_12;
    mem[16'h0800] = 8'hD3;
    {mem[16'hFFFF], mem[16'h0000], mem[16'h0001]} = 24'hC3_50_01;

    IF_RST   = 1'b1;
    IF_FLUSH = 1'b0;
    IF_READY = 1'b0;
    load_pc  = 16'h0100;

    // Reset state
    repeat (3) @(negedge IF_CLK);
    #1;
    chk("rst_valid",    IF_VALID,    0);
    chk("rst_cb",       IF_CB,       0);
    chk("rst_len",      IF_LEN,      0);
    chk("rst_opcode",   IF_OPCODE,   0);
    chk("rst_imm",      IF_IMM,      0);
    chk("rst_instr_pc", IF_INSTR_PC, 0);
    chk("rst_mem_rd",   IF_MEM_RD,   0);
    chk("rst_pc_inc",   IF_PC_INC,   0);

    // NOP at 0x0100
    IF_RST = 1'b0;
    push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0100);
    wait_valid("nop");

    // LD BC,d16 then JR r8, the second fetched after a normal acceptance
    push(8'h01, 1'b0, 16'h1234, 2'd3, 16'h0200);
    push(8'h18, 1'b0, 16'h00FE, 2'd2, 16'h0203);
    accept_and_jump(16'h0200);
    wait_valid("ld_bc");
    IF_READY = 1'b1;
    @(negedge IF_CLK);
    #1;
    IF_READY = 1'b0;
    wait_valid("jr");

    // CB-prefixed BIT 7,H
    push(8'h7C, 1'b1, 16'h0000, 2'd2, 16'h0300);
    accept_and_jump(16'h0300);
    wait_valid("cb_bit");

    // Three wait cycles per byte, then a 5-cycle decoder stall
    mem_wait = 3;
    push(8'h21, 1'b0, 16'hABCD, 2'd3, 16'h0400);
    accept_and_jump(16'h0400);
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 4; w++) begin
        if (!(b == 0 && w == 0)) begin
          @(negedge IF_CLK);
          #1;
        end
        chk("wait_mem_rd", IF_MEM_RD,   1);
        chk("wait_addr",   IF_MEM_ADDR, 16'h0400 + 16'(b));
        chk("wait_pc_inc", IF_PC_INC,   (w == 3) ? 1 : 0);
      end
    end
    repeat (5) begin
      @(negedge IF_CLK);
      #1;
      chk("stall_valid",  IF_VALID,  1);
      chk("stall_mem_rd", IF_MEM_RD, 0);
    end
    mem_wait = 0;

    // Flush coinciding with the S_LO byte of LD HL,d16
    accept_and_jump(16'h0500);
    @(negedge IF_CLK);
    #1;
    IF_FLUSH = 1'b1;
    load_pc  = 16'h0600;
    #1;
    chk("flush_lo_addr", IF_MEM_ADDR, 16'h0501);
    chk("flush_mem_rd",  IF_MEM_RD,   1);
    chk("flush_pc_inc",  IF_PC_INC,   0);
    push(8'h3E, 1'b0, 16'h0055, 2'd2, 16'h0600);
    @(negedge IF_CLK);
    #1;
    IF_FLUSH = 1'b0;
    #1;
    chk("post_flush_addr",  IF_MEM_ADDR, 16'h0600);
    chk("post_flush_rd",    IF_MEM_RD,   1);
    chk("post_flush_valid", IF_VALID,    0);
    wait_valid("ld_a");

    // Reset while in S_HI of LD A,(a16)
    accept_and_jump(16'h0700);
    @(negedge IF_CLK);
    #1;
    @(negedge IF_CLK);
    #1;
    chk("hi_addr", IF_MEM_ADDR, 16'h0702);
    IF_RST  = 1'b1;
    load_pc = 16'h0800;
    #1;
    chk("rst_hi_pc_inc", IF_PC_INC, 0);
    chk("rst_hi_mem_rd", IF_MEM_RD, 0);
    @(negedge IF_CLK);
    #1;
    IF_RST = 1'b0;
    #1;
    chk("rst2_valid",    IF_VALID,    0);
    chk("rst2_cb",       IF_CB,       0);
    chk("rst2_len",      IF_LEN,      0);
    chk("rst2_opcode",   IF_OPCODE,   0);
    chk("rst2_imm",      IF_IMM,      0);
    chk("rst2_instr_pc", IF_INSTR_PC, 0);
    chk("rst2_mem_rd",   IF_MEM_RD,   0);
    chk("rst2_pc_inc",   IF_PC_INC,   0);
    push(8'hD3, 1'b0, 16'h0000, 2'd1, 16'h0800);
    @(negedge IF_CLK);
    #1;
    chk("restart_rd",   IF_MEM_RD,   1);
    chk("restart_addr", IF_MEM_ADDR, 16'h0800);
    wait_valid("illegal_d3");

    // JP a16 straddling the 0xFFFF -> 0x0000 wrap
    push(8'hC3, 1'b0, 16'h0150, 2'd3, 16'hFFFF);
    accept_and_jump(16'hFFFF);
    wait_valid("jp_wrap");

    repeat (3) @(negedge IF_CLK);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters: none; the opcode length table and state encoding are fixed.
REQ-002 IF_CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 IF_RST  in  1  synchronous, active-high reset.
REQ-004 IF_PC  in  16  current program counter value from the PC counter.
REQ-005 IF_PC_INC  out  1  one-cycle increment pulse to the PC counter.
REQ-006 IF_FLUSH  in  1  abort the current fetch; asserted in the same cycle the PC counter is loaded (branch, jump, interrupt).
REQ-007 IF_MEM_ADDR  out  16  byte read address; equals IF_PC whenever IF_MEM_RD is high.
REQ-008 IF_MEM_RD  out  1  read request, held high until accepted.
REQ-009 IF_MEM_DATA  in  8  read data, valid only while IF_MEM_VALID is high.
REQ-010 IF_MEM_VALID  in  1  read completes this cycle; ignored while IF_MEM_RD is low.
REQ-011 IF_OPCODE  out  8  opcode byte (the second byte for CB-prefixed instructions).
REQ-012 IF_CB  out  1  instruction carried the 0xCB prefix.
REQ-013 IF_IMM  out  16  immediate operand, little-endian {hi,lo}; {8'h00,lo} for 1-byte immediates; 0 if none.
REQ-014 IF_LEN  out  2  total instruction length in bytes (1..3).
REQ-015 IF_INSTR_PC  out  16  address of the instruction's first byte.
REQ-016 IF_VALID  out  1  instruction bundle valid.
REQ-017 IF_READY  in  1  decoder accepts the bundle.

Function
REQ-018 The FSM SHALL have states S_OP, S_CB, S_LO, S_HI, S_OUT.
REQ-019 In S_OP/S_CB/S_LO/S_HI: IF_MEM_RD=1, IF_MEM_ADDR=IF_PC; IF_MEM_ADDR is held stable while IF_MEM_VALID=0.
REQ-020 In a fetch state, a cycle with IF_MEM_VALID=1 and IF_FLUSH=0 captures IF_MEM_DATA, drives IF_PC_INC=1 for that cycle only, and advances the FSM.
REQ-021 S_OP capture: latch IF_INSTR_PC=IF_PC, then branch on the byte:
- 0xCB -> S_CB;
- table length 1 -> S_OUT;
- otherwise -> S_LO.
REQ-022 S_CB capture -> S_OUT with IF_CB=1, IF_LEN=2, IF_IMM=0.
REQ-023 S_LO capture: length 3 -> S_HI, else -> S_OUT.
REQ-024 S_HI capture -> S_OUT.
REQ-025 Illegal SM83 opcodes (D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD) SHALL be treated as length 1.
REQ-026 In S_OUT: IF_VALID=1 and IF_MEM_RD=0; all bundle outputs are stable; IF_VALID&IF_READY -> S_OP next cycle. First fetch latency is 1 cycle after acceptance.
REQ-027 IF_FLUSH=1 in any state:
- next state is S_OP;
- IF_VALID=0 from the next cycle;
- IF_PC_INC=0 this cycle, even if IF_MEM_VALID=1;
- any captured bytes are discarded.
REQ-028 IF_FLUSH takes priority over IF_MEM_VALID and IF_READY when they coincide.
REQ-029 IF_PC_INC SHALL never pulse outside a capturing cycle; exactly IF_LEN pulses occur per delivered instruction.
REQ-030 PC wrap 0xFFFF -> 0x0000 is the counter's concern; multi-byte fetches across the wrap SHALL proceed normally.

Reset
REQ-031 While IF_RST=1:
- state=S_OP;
- IF_VALID, IF_CB, IF_LEN, IF_OPCODE, IF_IMM, IF_INSTR_PC = 0;
- IF_MEM_RD=0, IF_PC_INC=0.
REQ-032 Reset mid-instruction discards the partial bundle; fetch restarts from IF_PC in the cycle after IF_RST deasserts.

Structure
REQ-033 Package sm83_pkg SHALL hold:
- the state enum;
- the CB_PREFIX constant;
- function op_len(byte) -> 2-bit length table.
REQ-034 No sub-module; the length table is a package function.

Verification
REQ-035 PC=0x0100, mem[0x0100]=0x00, 1-cycle memory -> IF_VALID, OPCODE=00, LEN=1, IMM=0, INSTR_PC=0x0100, one INC pulse.
REQ-036 Bytes 01 34 12 at 0x0200 -> OPCODE=01, IMM=0x1234, LEN=3, three INC pulses, PC ends at 0x0203; bytes 18 FE -> IMM=0x00FE, LEN=2.
REQ-037 Bytes CB 7C -> IF_CB=1, OPCODE=7C, LEN=2, IMM=0.
REQ-038 3 wait cycles per byte -> MEM_RD held with ADDR stable and no INC until VALID; then READY=0 for 5 cycles -> bundle held, MEM_RD=0.
REQ-039 Flush coincident with MEM_VALID in S_LO of 0x21 -> no INC that cycle, no IF_VALID, next read at the new loaded PC.
REQ-040 IF_RST pulsed during S_HI -> all outputs 0 next cycle, then a clean fetch from IF_PC.
